// File: rtl/int_to_float.sv
// int_to_float: multi-cycle integer to binary-float converter.
// Normalises one bit per cycle, then rounds with one of four modes and
// reports whether the result is inexact.
//
// Handshake (both ports): a transfer happens on a rising edge where the
// producer's stb and the consumer's ack are both high. input_a_ack is only
// raised in GET, so one conversion is in flight at a time. output_z_stb,
// once raised, stays high with output_z/output_z_inexact frozen until
// output_z_ack is seen high on an edge.
module int_to_float #(
  parameter int INT_WIDTH = 64,
  parameter int EXP_WIDTH = 11,
  parameter int MAN_WIDTH = 52,
  parameter int SIGNED    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INT_WIDTH-1:0]         input_a,
  input  logic [1:0]                   input_rm,
  input  logic                         input_a_stb,
  output logic                         input_a_ack,
  output logic [EXP_WIDTH+MAN_WIDTH:0] output_z,
  output logic                         output_z_inexact,
  output logic                         output_z_stb,
  input  logic                         output_z_ack,
  output logic [2:0]                   dbg_state
);

  localparam int ZW    = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int SW    = MAN_WIDTH + 1;
  localparam int EXT_W = INT_WIDTH + MAN_WIDTH + 3;

  localparam logic [EXP_WIDTH-1:0] BIAS    = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_TOP = EXP_WIDTH'(INT_WIDTH - 1);

  localparam logic [2:0] GET   = 3'd0;
  localparam logic [2:0] ABS   = 3'd1;
  localparam logic [2:0] NORM  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] PACK  = 3'd4;
  localparam logic [2:0] PUT   = 3'd5;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_POS = 2'b10;

  logic [2:0]           state_q, state_d;
  logic [INT_WIDTH-1:0] a_q, a_d;
  logic [1:0]           rm_q, rm_d;
  logic [INT_WIDTH-1:0] mag_q, mag_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic                 zero_q, zero_d;
  logic [MAN_WIDTH-1:0] frac_q, frac_d;
  logic                 inexact_q, inexact_d;
  logic [ZW-1:0]        res_q, res_d;
  logic                 ack_q, ack_d;
  logic                 stb_q, stb_d;
  logic [ZW-1:0]        z_q, z_d;
  logic                 z_inexact_q, z_inexact_d;

  // Normalised magnitude padded below so guard/round/sticky always exist;
  // missing low bits of a narrow integer simply read as zero.
  logic [EXT_W-1:0] ext;
  logic [SW-1:0]    sig_trunc;
  logic [SW:0]      sig_inc;
  logic             g_bit, r_bit, s_bit, round_up;
  logic [INT_WIDTH-1:0] neg_a;

  assign ext       = {mag_q, {(MAN_WIDTH + 3){1'b0}}};
  assign sig_trunc = ext[EXT_W-1 -: SW];
  assign g_bit     = ext[EXT_W-SW-1];
  assign r_bit     = ext[EXT_W-SW-2];
  assign s_bit     = |ext[EXT_W-SW-3:0];
  assign sig_inc   = {1'b0, sig_trunc} + (SW + 1)'(1);
  assign neg_a     = -a_q;

  // Rounding increment decision for the latched rounding mode.
  always_comb begin
    round_up = 1'b0;
    case (rm_q)
      RM_RNE:  round_up = g_bit & (r_bit | s_bit | sig_trunc[0]);
      RM_RTZ:  round_up = 1'b0;
      RM_POS:  round_up = (g_bit | r_bit | s_bit) & ~sign_q;
      default: round_up = (g_bit | r_bit | s_bit) & sign_q;
    endcase
  end

  // Next-state and datapath updates for the conversion sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    rm_d        = rm_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    frac_d      = frac_q;
    inexact_d   = inexact_q;
    res_d       = res_q;
    ack_d       = ack_q;
    stb_d       = stb_q;
    z_d         = z_q;
    z_inexact_d = z_inexact_q;
    case (state_q)
      GET: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          rm_d    = input_rm;
          ack_d   = 1'b0;
          state_d = ABS;
        end
      end
      ABS: begin
        if (a_q == '0) begin
          sign_d    = 1'b0;
          zero_d    = 1'b1;
          inexact_d = 1'b0;
          state_d   = PACK;
        end else begin
          // The most negative value negates to 100..0, its true magnitude.
          sign_d  = (SIGNED != 0) && a_q[INT_WIDTH-1];
          mag_d   = ((SIGNED != 0) && a_q[INT_WIDTH-1]) ? neg_a : a_q;
          exp_d   = EXP_TOP;
          zero_d  = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (!mag_q[INT_WIDTH-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_WIDTH'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        inexact_d = g_bit | r_bit | s_bit;
        if (round_up) begin
          // Carry out leaves the fraction at zero with the exponent bumped.
          frac_d = sig_inc[MAN_WIDTH-1:0];
          if (sig_inc[SW]) exp_d = exp_q + EXP_WIDTH'(1);
        end else begin
          frac_d = sig_trunc[MAN_WIDTH-1:0];
        end
        state_d = PACK;
      end
      PACK: begin
        res_d   = zero_q ? '0 : {sign_q, exp_q + BIAS, frac_q};
        state_d = PUT;
      end
      PUT: begin
        if (!stb_q) begin
          stb_d       = 1'b1;
          z_d         = res_q;
          z_inexact_d = inexact_q;
        end else if (output_z_ack) begin
          stb_d   = 1'b0;
          state_d = GET;
        end
      end
      default: state_d = GET;
    endcase
  end

  // State registers with synchronous reset overriding every state action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GET;
      a_q         <= '0;
      rm_q        <= '0;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      frac_q      <= '0;
      inexact_q   <= 1'b0;
      res_q       <= '0;
      ack_q       <= 1'b0;
      stb_q       <= 1'b0;
      z_q         <= '0;
      z_inexact_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      rm_q        <= rm_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      frac_q      <= frac_d;
      inexact_q   <= inexact_d;
      res_q       <= res_d;
      ack_q       <= ack_d;
      stb_q       <= stb_d;
      z_q         <= z_d;
      z_inexact_q <= z_inexact_d;
    end
  end

  assign input_a_ack      = ack_q;
  assign output_z_stb     = stb_q;
  assign output_z         = z_q;
  assign output_z_inexact = z_inexact_q;
  assign dbg_state        = state_q;

endmodule
